// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, operand/result widths, command and FSM encodings.
package alu_pkg;
  localparam int OPW  = 4;
  localparam int RESW = 5;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    NOT = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    alu_op_e        op;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } seq_state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH a power of two; dout shows the head combinationally.
// Push is dropped while full even if a pop happens in the same cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t din,
  output logic full,
  input  logic pop,
  output cmd_t dout,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Single-issue ALU sequencer: queues commands, drives registered operands, holds each result until taken (3 edges push->result).
// cmd_ready drops while the queue is full; define ALU_SEQ_STATS_EN for a saturating completed-result counter.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  input  logic [1:0]      cmd_op,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [1:0]      alu_opcode,
  output logic            alu_rst_n,
  input  logic [RESW-1:0] alu_c,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data,
  output logic [1:0]      res_op,
  output logic [7:0]      issued_cnt
);
  cmd_t       fifo_din;
  cmd_t       fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       capture;
  logic [1:0] op_lat;
  seq_state_e state;
  seq_state_e state_nxt;

  assign fifo_din  = {cmd_a, cmd_b, cmd_op};
  assign cmd_ready = !fifo_full;
  assign alu_rst_n = ~rst;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_HOLD;
      S_HOLD:  if (res_ready) state_nxt = fifo_empty ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A pop from HOLD on handshake skips IDLE, giving one result every 3 cycles.
  always_comb begin
    res_valid = (state == S_HOLD);
    capture   = (state == S_WAIT);
    fifo_pop  = !fifo_empty && ((state == S_IDLE) || ((state == S_HOLD) && res_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      op_lat     <= '0;
      res_data   <= '0;
      res_op     <= '0;
    end else begin
      if (fifo_pop) begin
        alu_a      <= fifo_dout.a;
        alu_b      <= fifo_dout.b;
        alu_opcode <= fifo_dout.op;
        op_lat     <= fifo_dout.op;
      end
      if (capture) begin
        res_data <= alu_c;
        res_op   <= op_lat;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] stat_cnt;

  always_ff @(posedge clk) begin
    if (rst) stat_cnt <= '0;
    else if (res_valid && res_ready && (stat_cnt != 8'hFF)) stat_cnt <= stat_cnt + 8'd1;
  end

  assign issued_cnt = stat_cnt;
`else
  assign issued_cnt = '0;
`endif
endmodule
